// File: rtl/pattern_frame_gen.sv
// pattern_frame_gen: RS-frame-shaped pattern source (counter / PRBS31 / constant) on a DATA_W valid/ready stream.
// Latency: start at edge t -> first beat (sof) visible from cycle t+1; one beat per cycle on back-to-back transfers.
// Backpressure: beat held while valid & !(out_ready & en); gap counter advances on en cycles only.
// Optional build macro PFG_ERR_INJECT_EN adds err_inject / err_count (data[0] flipped on beats loaded with err_inject=1).
module pattern_frame_gen #(
    parameter int          RS_K            = 60,
    parameter int          RS_N            = 68,
    parameter int          RS_SYMBOL_WIDTH = 8,
    parameter int          DATA_W          = 8,
    parameter logic [63:0] SEED            = 64'h1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [RS_SYMBOL_WIDTH-1:0] pattern,
    input  logic [31:0]                n_frames,
    input  logic                       out_ready,
`ifdef PFG_ERR_INJECT_EN
    input  logic                       err_inject,
    output logic [31:0]                err_count,
`endif
    output logic [DATA_W-1:0]          data,
    output logic                       valid,
    output logic                       sof,
    output logic                       eof,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                frame_count
);

    localparam int BPS        = RS_SYMBOL_WIDTH / DATA_W;
    localparam int INFO_BEATS = RS_K * BPS;
    localparam int GAP_CYCLES = (RS_N - RS_K) * BPS;
    localparam int BI_W       = (INFO_BEATS > 1) ? $clog2(INFO_BEATS) : 1;
    localparam int GC_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int SB_W       = (BPS > 1) ? $clog2(BPS) : 1;
    localparam logic [30:0] SEED31 = (SEED[30:0] == 31'd0) ? 31'd1 : SEED[30:0];

    if (RS_SYMBOL_WIDTH % DATA_W != 0) begin : g_bad_data_w
        $error("pattern_frame_gen: DATA_W must divide RS_SYMBOL_WIDTH");
    end
    if (RS_N < RS_K) begin : g_bad_rs_n
        $error("pattern_frame_gen: RS_N must be >= RS_K");
    end

    typedef enum logic [1:0] {S_IDLE, S_INFO, S_GAP, S_DONE} state_t;

    state_t                     state_q;
    logic [1:0]                 mode_q;
    logic [RS_SYMBOL_WIDTH-1:0] pat_q;
    logic [31:0]                nfr_q;
    logic [31:0]                frame_cnt_q;
    logic [BI_W-1:0]            beat_idx_q;
    logic [GC_W-1:0]            gap_q;
    logic [30:0]                lfsr_q;
    logic [RS_SYMBOL_WIDTH-1:0] sym_q;
    logic [SB_W-1:0]            sub_q;
    logic [DATA_W-1:0]          data_q;
    logic                       valid_q, sof_q, eof_q, busy_q, done_q;

    // control events
    logic            start_ok, xfer, last_beat, gap_end, frame_end, more, load;
    logic [BI_W-1:0] load_idx;
    logic [31:0]     fc_inc;

    // beat generator: source state, next state and produced beat
    logic [1:0]                 src_mode;
    logic [RS_SYMBOL_WIDTH-1:0] src_pat, src_sym, sym_val, sym_shift, sym_d;
    logic [SB_W-1:0]            src_sub, sub_d;
    logic [30:0]                src_lfsr, lfsr_d;
    logic [DATA_W-1:0]          prbs_dat, beat_d, beat_o;
    logic                       fb;

    // Decode this cycle's transfer, gap-end, end-of-frame and beat-load events
    always_comb begin
        start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
        xfer      = (state_q == S_INFO) && valid_q && out_ready && en;
        last_beat = (beat_idx_q == BI_W'(INFO_BEATS - 1));
        gap_end   = (state_q == S_GAP) && en && (gap_q == GC_W'(GAP_CYCLES - 1));
        frame_end = gap_end || (xfer && last_beat && (GAP_CYCLES == 0));
        fc_inc    = frame_cnt_q + 32'd1;
        more      = (fc_inc != nfr_q);
        load      = (start_ok && (n_frames != 32'd0)) || (xfer && !last_beat) || (frame_end && more);
        load_idx  = (xfer && !last_beat) ? beat_idx_q + 1'b1 : '0;
    end

    // Produce the next beat; a start reloads the generator from seed/zero and the live mode inputs
    always_comb begin
        if (start_ok) begin
            src_mode = mode;
            src_pat  = pattern;
            src_sym  = '0;
            src_sub  = '0;
            src_lfsr = SEED31;
        end else begin
            src_mode = mode_q;
            src_pat  = pat_q;
            src_sym  = sym_q;
            src_sub  = sub_q;
            src_lfsr = lfsr_q;
        end
        sym_val   = (src_mode == 2'd2) ? src_pat : src_sym;
        sym_shift = sym_val >> (32'(src_sub) * DATA_W);
        // PRBS31: first generated bit lands in data[0]
        fb       = 1'b0;
        prbs_dat = '0;
        lfsr_d   = src_lfsr;
        for (int i = 0; i < DATA_W; i++) begin
            fb          = lfsr_d[30] ^ lfsr_d[27];
            lfsr_d      = {lfsr_d[29:0], fb};
            prbs_dat[i] = fb;
        end
        beat_d = (src_mode == 2'd1) ? prbs_dat : sym_shift[DATA_W-1:0];
        // counter symbol advances after its last slice has been loaded
        if (src_sub == SB_W'(BPS - 1)) begin
            sub_d = '0;
            sym_d = src_sym + 1'b1;
        end else begin
            sub_d = src_sub + 1'b1;
            sym_d = src_sym;
        end
        beat_o = beat_d;
`ifdef PFG_ERR_INJECT_EN
        beat_o[0] = beat_d[0] ^ err_inject;
`endif
    end

`ifdef PFG_ERR_INJECT_EN
    logic [31:0] err_cnt_q;

    // Count beats loaded with an injected error; a start begins a fresh count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_q <= '0;
        end else if (load && err_inject) begin
            err_cnt_q <= (start_ok ? 32'd0 : err_cnt_q) + 32'd1;
        end else if (start_ok) begin
            err_cnt_q <= '0;
        end
    end

    assign err_count = err_cnt_q;
`endif

    // Frame FSM plus registered stream outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            pat_q       <= '0;
            nfr_q       <= '0;
            frame_cnt_q <= '0;
            beat_idx_q  <= '0;
            gap_q       <= '0;
            lfsr_q      <= SEED31;
            sym_q       <= '0;
            sub_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        mode_q      <= mode;
                        pat_q       <= pattern;
                        nfr_q       <= n_frames;
                        frame_cnt_q <= '0;
                        gap_q       <= '0;
                        beat_idx_q  <= '0;
                        sym_q       <= '0;
                        sub_q       <= '0;
                        lfsr_q      <= SEED31;
                        if (n_frames == 32'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_INFO;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_INFO: begin
                    if (xfer && last_beat) begin
                        valid_q <= 1'b0;
                        sof_q   <= 1'b0;
                        eof_q   <= 1'b0;
                        if (GAP_CYCLES != 0) begin
                            state_q <= S_GAP;
                            gap_q   <= '0;
                        end
                    end
                end
                S_GAP: begin
                    if (en && !gap_end) begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // end-of-frame: either start the next frame or finish the run
            if (frame_end) begin
                frame_cnt_q <= fc_inc;
                if (more) begin
                    state_q <= S_INFO;
                end else begin
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
            if (load) begin
                data_q     <= beat_o;
                valid_q    <= 1'b1;
                sof_q      <= (load_idx == '0);
                eof_q      <= (load_idx == BI_W'(INFO_BEATS - 1));
                beat_idx_q <= load_idx;
                lfsr_q     <= lfsr_d;
                sym_q      <= sym_d;
                sub_q      <= sub_d;
            end
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign sof         = sof_q;
    assign eof         = eof_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_pattern_frame_gen.sv
// tb_pattern_frame_gen: scoreboard bench for pattern_frame_gen (DATA_W=8 main instance, DATA_W=1 side instance).
// Inputs driven 1ns after the rising edge; transfers and gaps sampled on the falling edge.
// Expected beats come from a bench-side model and are compared in order against collected transfers.
`timescale 1ns/1ps
module tb_pattern_frame_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, start, start1, out_ready;
    logic [1:0]  mode;
    logic [7:0]  pattern;
    logic [31:0] n_frames;

    logic [7:0]  data;
    logic        valid, sof, eof, busy, done;
    logic [31:0] frame_count;
    logic [0:0]  data1;
    logic        valid1, sof1, eof1, busy1, done1;
    logic [31:0] frame_count1;
`ifdef PFG_ERR_INJECT_EN
    logic        err_inject;
    logic [31:0] err_count, err_count1;
`endif

    pattern_frame_gen #(.RS_K(60), .RS_N(68), .RS_SYMBOL_WIDTH(8), .DATA_W(8), .SEED(64'h1)) dut (
        .clk(clk), .rstn(rstn), .en(en), .start(start), .mode(mode), .pattern(pattern),
        .n_frames(n_frames), .out_ready(out_ready),
`ifdef PFG_ERR_INJECT_EN
        .err_inject(err_inject), .err_count(err_count),
`endif
        .data(data), .valid(valid), .sof(sof), .eof(eof), .busy(busy), .done(done),
        .frame_count(frame_count)
    );

    pattern_frame_gen #(.RS_K(60), .RS_N(68), .RS_SYMBOL_WIDTH(8), .DATA_W(1), .SEED(64'h1)) dut1 (
        .clk(clk), .rstn(rstn), .en(en), .start(start1), .mode(mode), .pattern(pattern),
        .n_frames(n_frames), .out_ready(out_ready),
`ifdef PFG_ERR_INJECT_EN
        .err_inject(err_inject), .err_count(err_count1),
`endif
        .data(data1), .valid(valid1), .sof(sof1), .eof(eof1), .busy(busy1), .done(done1),
        .frame_count(frame_count1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } beat_t;

    int    vec  = 0;
    int    errs = 0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    int    gap_q[$];
    logic  obs1_q[$];
    int    gcnt   = 0;
    bit    in_gap = 0;

    // collect transfers and per-frame gap lengths (en cycles with busy & !valid)
    always @(negedge clk) begin
        if (valid === 1'b1 && out_ready && en) obs_q.push_back({data, sof, eof});
        if (valid1 === 1'b1 && out_ready && en) obs1_q.push_back(data1[0]);
        if (busy === 1'b1 && valid === 1'b0) begin
            in_gap = 1;
            if (en) gcnt++;
        end else if (in_gap) begin
            gap_q.push_back(gcnt);
            in_gap = 0;
            gcnt   = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic beat_t cnt_beat(input int k);
        beat_t b;
        b.d = 8'(k % 256);
        b.s = ((k % 60) == 0);
        b.e = ((k % 60) == 59);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        gap_q.delete();
        obs1_q.delete();
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [7:0] p, input logic [31:0] n);
        mode     = m;
        pattern  = p;
        n_frames = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; out_ready = 1'b1; start = 1'b0; start1 = 1'b0;
        mode = 2'd0; pattern = 8'h00; n_frames = 32'd0;
`ifdef PFG_ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        repeat (3) tick();
        vec++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid); end
        vec++; if (data !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", data); end
        vec++; if ({sof, eof, busy, done} !== 4'b0000) begin
            errs++; $display("FAIL reset_flags: sof/eof/busy/done got %b want 0000", {sof, eof, busy, done});
        end
        vec++; if (frame_count !== 32'd0) begin errs++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_counter();
        beat_t b, o;
        int c;
        clear_q();
        for (int k = 0; k < 120; k++) exp_q.push_back(cnt_beat(k));
        pulse_start(2'd0, 8'h00, 32'd2);
        vec++; if ({valid, sof, data} !== {1'b1, 1'b1, 8'h00}) begin
            errs++; $display("FAIL counter_first_beat: valid/sof/data got %b/%b/%h want 1/1/00", valid, sof, data);
        end
        c = 0;
        while (done !== 1'b1 && c < 1000) begin tick(); c++; end
        tick();
        vec++; if (c != 136) begin errs++; $display("FAIL counter_run_cycles: got %0d want 136", c); end
        vec++; if (obs_q.size() != 120) begin errs++; $display("FAIL counter_beat_count: got %0d want 120", obs_q.size()); end
        for (int k = 0; k < 120 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            vec++; if (o !== b) begin
                errs++; $display("FAIL counter_beat %0d: got d=%h sof=%b eof=%b want d=%h sof=%b eof=%b", k, o.d, o.s, o.e, b.d, b.s, b.e);
            end
        end
        vec++; if (gap_q.size() != 2) begin errs++; $display("FAIL counter_gap_count: got %0d want 2", gap_q.size()); end
        while (gap_q.size() > 0) begin
            c = gap_q.pop_front();
            vec++; if (c != 8) begin errs++; $display("FAIL counter_gap_len: got %0d want 8", c); end
        end
        vec++; if ({done, busy, frame_count} !== {1'b1, 1'b0, 32'd2}) begin
            errs++; $display("FAIL counter_end: done/busy/frame_count got %b/%b/%0d want 1/0/2", done, busy, frame_count);
        end
    endtask

    task automatic test_prbs();
        logic [30:0] s;
        logic        nb;
        beat_t       b, o;
        beat_t       run1[60];
        int          c;
        clear_q();
        s = 31'd1;
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 8; i++) begin
                nb = s[30] ^ s[27];
                s = {s[29:0], nb};
                b.d[i] = nb;
            end
            b.s = (k == 0); b.e = (k == 59);
            exp_q.push_back(b);
        end
        pulse_start(2'd1, 8'h00, 32'd1);
        c = 0;
        while (done !== 1'b1 && c < 500) begin tick(); c++; end
        tick();
        vec++; if (obs_q.size() != 60) begin errs++; $display("FAIL prbs_beat_count: got %0d want 60", obs_q.size()); end
        for (int k = 0; k < 60 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front(); run1[k] = o;
            vec++; if (o !== b) begin
                errs++; $display("FAIL prbs_beat %0d: got d=%h sof=%b eof=%b want d=%h sof=%b eof=%b", k, o.d, o.s, o.e, b.d, b.s, b.e);
            end
        end
        vec++; if ({run1[0].d, run1[1].d, run1[2].d} !== 24'h000000) begin
            errs++; $display("FAIL prbs_beats_0_2: got %h %h %h want 00 00 00", run1[0].d, run1[1].d, run1[2].d);
        end
        vec++; if (run1[3].d !== 8'h48) begin errs++; $display("FAIL prbs_beat_3: got %h want 48", run1[3].d); end
        // restart from DONE must replay the identical sequence
        clear_q();
        for (int k = 0; k < 60; k++) exp_q.push_back(run1[k]);
        pulse_start(2'd1, 8'h00, 32'd1);
        c = 0;
        while (done !== 1'b1 && c < 500) begin tick(); c++; end
        tick();
        vec++; if (obs_q.size() != 60) begin errs++; $display("FAIL prbs_restart_count: got %0d want 60", obs_q.size()); end
        for (int k = 0; k < 60 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            vec++; if (o !== b) begin errs++; $display("FAIL prbs_restart_beat %0d: got d=%h want d=%h", k, o.d, b.d); end
        end
    endtask

    task automatic test_constant();
        beat_t b, o;
        int c;
        clear_q();
        for (int k = 0; k < 60; k++) begin
            b.d = 8'hA5; b.s = (k == 0); b.e = (k == 59);
            exp_q.push_back(b);
        end
        pulse_start(2'd2, 8'hA5, 32'd1);
        pattern = 8'h3C;
        c = 0;
        while (done !== 1'b1 && c < 500) begin tick(); c++; end
        tick();
        vec++; if (obs_q.size() != 60) begin errs++; $display("FAIL const_beat_count: got %0d want 60", obs_q.size()); end
        for (int k = 0; k < 60 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            vec++; if (o !== b) begin errs++; $display("FAIL const_beat %0d: got d=%h sof=%b eof=%b want d=%h", k, o.d, o.s, o.e, b.d); end
        end
    endtask

    task automatic test_backpressure();
        beat_t b, o;
        logic [10:0] snap;
        logic        stall;
        int          c, gdrop;
        bit          dropped;
        clear_q();
        for (int k = 0; k < 120; k++) exp_q.push_back(cnt_beat(k));
        pulse_start(2'd0, 8'h00, 32'd2);
        c = 0; gdrop = 0; dropped = 0;
        while (done !== 1'b1 && c < 2000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (busy && !valid && !dropped) begin gdrop = 3; dropped = 1; end
            en = !((c >= 30 && c < 35) || gdrop > 0);
            if (gdrop > 0) gdrop--;
            snap  = {valid, data, sof, eof};
            stall = valid && !(out_ready && en);
            tick();
            c++;
            if (stall) begin
                vec++; if ({valid, data, sof, eof} !== snap) begin
                    errs++; $display("FAIL bp_hold cycle %0d: got %h want %h", c, {valid, data, sof, eof}, snap);
                end
            end
        end
        en = 1'b1; out_ready = 1'b1;
        tick();
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL bp_done: got %b want 1 (after %0d cycles)", done, c); end
        vec++; if (obs_q.size() != 120) begin errs++; $display("FAIL bp_beat_count: got %0d want 120", obs_q.size()); end
        for (int k = 0; k < 120 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            vec++; if (o !== b) begin
                errs++; $display("FAIL bp_beat %0d: got d=%h sof=%b eof=%b want d=%h sof=%b eof=%b", k, o.d, o.s, o.e, b.d, b.s, b.e);
            end
        end
        while (gap_q.size() > 0) begin
            c = gap_q.pop_front();
            vec++; if (c != 8) begin errs++; $display("FAIL bp_gap_len: got %0d want 8", c); end
        end
        vec++; if (frame_count !== 32'd2) begin errs++; $display("FAIL bp_frame_count: got %0d want 2", frame_count); end
    endtask

    task automatic test_edge();
        beat_t b, o;
        int c;
        // zero frames: straight to DONE without any beat
        clear_q();
        pulse_start(2'd0, 8'h00, 32'd0);
        vec++; if ({done, busy, valid, frame_count} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            errs++; $display("FAIL nf0_state: done/busy/valid/fc got %b/%b/%b/%0d want 1/0/0/0", done, busy, valid, frame_count);
        end
        repeat (4) tick();
        vec++; if (obs_q.size() != 0) begin errs++; $display("FAIL nf0_no_beats: got %0d want 0", obs_q.size()); end
        // start while busy is ignored, changed inputs have no effect
        clear_q();
        for (int k = 0; k < 60; k++) exp_q.push_back(cnt_beat(k));
        pulse_start(2'd0, 8'h00, 32'd1);
        repeat (10) tick();
        pulse_start(2'd2, 8'hFF, 32'd5);
        c = 0;
        while (done !== 1'b1 && c < 500) begin tick(); c++; end
        tick();
        vec++; if (obs_q.size() != 60) begin errs++; $display("FAIL ignore_start_count: got %0d want 60", obs_q.size()); end
        for (int k = 0; k < 60 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            vec++; if (o !== b) begin errs++; $display("FAIL ignore_start_beat %0d: got d=%h want d=%h", k, o.d, b.d); end
        end
        vec++; if (frame_count !== 32'd1) begin errs++; $display("FAIL ignore_start_fc: got %0d want 1", frame_count); end
        // reset mid-frame
        pulse_start(2'd0, 8'h00, 32'd3);
        repeat (20) tick();
        rstn = 1'b0;
        tick();
        vec++; if ({valid, data, sof, eof, busy, done, frame_count} !== '0) begin
            errs++; $display("FAIL midrun_reset: valid/data/sof/eof/busy/done/fc got %b/%h/%b/%b/%b/%b/%0d want all 0",
                             valid, data, sof, eof, busy, done, frame_count);
        end
        rstn = 1'b1;
        clear_q();
        repeat (10) tick();
        vec++; if ({valid, busy, done} !== 3'b000 || obs_q.size() != 0) begin
            errs++; $display("FAIL midrun_reset_idle: valid/busy/done got %b%b%b beats %0d want 000 and 0", valid, busy, done, obs_q.size());
        end
    endtask

    task automatic test_width1();
        logic e, o;
        int c;
        clear_q();
        mode = 2'd0; n_frames = 32'd1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        c = 0;
        while (done1 !== 1'b1 && c < 2000) begin tick(); c++; end
        tick();
        vec++; if (c != 544) begin errs++; $display("FAIL w1_run_cycles: got %0d want 544", c); end
        vec++; if (obs1_q.size() != 480) begin errs++; $display("FAIL w1_beat_count: got %0d want 480", obs1_q.size()); end
        for (int k = 0; k < 480 && obs1_q.size() > 0; k++) begin
            o = obs1_q.pop_front();
            e = ((k / 8) >> (k % 8)) & 1;
            vec++; if (o !== e) begin errs++; $display("FAIL w1_beat %0d: got %b want %b", k, o, e); end
        end
        vec++; if (frame_count1 !== 32'd1) begin errs++; $display("FAIL w1_frame_count: got %0d want 1", frame_count1); end
    endtask

`ifdef PFG_ERR_INJECT_EN
    task automatic test_err_inject();
        beat_t b, o;
        int c;
        clear_q();
        for (int k = 0; k < 60; k++) begin
            b = cnt_beat(k);
            if (k == 10) b.d = 8'h0B;
            exp_q.push_back(b);
        end
        pulse_start(2'd0, 8'h00, 32'd1);
        repeat (9) tick();
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        c = 0;
        while (done !== 1'b1 && c < 500) begin tick(); c++; end
        tick();
        vec++; if (obs_q.size() != 60) begin errs++; $display("FAIL inj_beat_count: got %0d want 60", obs_q.size()); end
        for (int k = 0; k < 60 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front(); b = exp_q.pop_front();
            vec++; if (o !== b) begin errs++; $display("FAIL inj_beat %0d: got d=%h want d=%h", k, o.d, b.d); end
        end
        vec++; if (err_count !== 32'd1) begin errs++; $display("FAIL inj_err_count: got %0d want 1", err_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_counter();
        test_prbs();
        test_constant();
        test_backpressure();
        test_edge();
        test_width1();
`ifdef PFG_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
